// File: rtl/atm_account_core.sv
// atm_account_core: PIN authentication and account operations
// over a 10-entry database of 16-bit balances and PINs.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req            one-cycle request strobe; other inputs sampled with it
//   operation      1=BALANCE 2=WITHDRAW 3=DEPOSIT 4=CHANGE_PIN 5=EXIT
//   acc_num        account index, 0..9 valid
//   pin, new_pin   entered PIN, replacement PIN for CHANGE_PIN
//   amount         unsigned amount for WITHDRAW/DEPOSIT
//   language       message language only, no functional effect
//   balance        registered balance result
//   current_state  registered state code
//   acc_found      combinational: acc_num in range
//   acc_auth       combinational: acc_found and PIN match
//   done, error    one-cycle result pulses, exactly one per req
module atm_account_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  operation,
    input  logic [3:0]  acc_num,
    input  logic [15:0] pin,
    input  logic [15:0] new_pin,
    input  logic [15:0] amount,
    input  logic        language,
    output logic [15:0] balance,
    output logic [2:0]  current_state,
    output logic        acc_found,
    output logic        acc_auth,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] OP_BAL  = 3'd1;
    localparam logic [2:0] OP_WD   = 3'd2;
    localparam logic [2:0] OP_DEP  = 3'd3;
    localparam logic [2:0] OP_CPIN = 3'd4;
    localparam logic [2:0] OP_EXIT = 3'd5;

    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_BAL  = 3'd1;
    localparam logic [2:0] ST_WD   = 3'd2;
    localparam logic [2:0] ST_DEP  = 3'd3;
    localparam logic [2:0] ST_CPIN = 3'd4;
    localparam logic [2:0] ST_MENU = 3'd6;

    logic [15:0] bal_mem [0:9];
    logic [15:0] pin_mem [0:9];

    logic [3:0]  idx;
    logic [15:0] stored_bal;
    logic [15:0] stored_pin;
    logic [16:0] sum17;
    logic        wd_ok;
    logic        dep_ok;

    // Language only affects simulation messaging elsewhere.
    logic unused_language;
    assign unused_language = language;

    // Out-of-range accounts read entry 0; acc_auth is gated by
    // acc_found so that read never authenticates.
    assign acc_found  = (acc_num <= 4'd9);
    assign idx        = acc_found ? acc_num : 4'd0;
    assign stored_bal = bal_mem[idx];
    assign stored_pin = pin_mem[idx];
    assign acc_auth   = acc_found && (pin == stored_pin);

    // 17-bit sum so deposit overflow shows up in the carry.
    assign sum17  = {1'b0, stored_bal} + {1'b0, amount};
    assign wd_ok  = (amount <= stored_bal);
    assign dep_ok = (sum17[16] == 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) begin
                bal_mem[i] <= 16'd500;
                pin_mem[i] <= 16'd1000 + 16'(i);
            end
            balance       <= 16'd0;
            current_state <= ST_WAIT;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (req) begin
                if (!acc_auth) begin
                    error         <= 1'b1;
                    current_state <= ST_WAIT;
                    balance       <= 16'd0;
                end else begin
                    unique case (operation)
                        OP_BAL: begin
                            balance       <= stored_bal;
                            current_state <= ST_BAL;
                            done          <= 1'b1;
                        end
                        OP_WD: begin
                            current_state <= ST_WD;
                            if (wd_ok) begin
                                bal_mem[idx] <= stored_bal - amount;
                                balance      <= stored_bal - amount;
                                done         <= 1'b1;
                            end else begin
                                balance <= stored_bal;
                                error   <= 1'b1;
                            end
                        end
                        OP_DEP: begin
                            current_state <= ST_DEP;
                            if (dep_ok) begin
                                bal_mem[idx] <= sum17[15:0];
                                balance      <= sum17[15:0];
                                done         <= 1'b1;
                            end else begin
                                balance <= stored_bal;
                                error   <= 1'b1;
                            end
                        end
                        OP_CPIN: begin
                            pin_mem[idx]  <= new_pin;
                            balance       <= stored_bal;
                            current_state <= ST_CPIN;
                            done          <= 1'b1;
                        end
                        OP_EXIT: begin
                            balance       <= 16'd0;
                            current_state <= ST_WAIT;
                            done          <= 1'b1;
                        end
                        default: begin
                            balance       <= stored_bal;
                            current_state <= ST_MENU;
                            error         <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_atm_account_core.sv
// Directed testbench for atm_account_core.
// Each scenario task drives vectors and checks hand-computed results.
module tb_atm_account_core;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [15:0] amount;
    logic        language;
    logic [15:0] balance;
    logic [2:0]  current_state;
    logic        acc_found;
    logic        acc_auth;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    atm_account_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .operation     (operation),
        .acc_num       (acc_num),
        .pin           (pin),
        .new_pin       (new_pin),
        .amount        (amount),
        .language      (language),
        .balance       (balance),
        .current_state (current_state),
        .acc_found     (acc_found),
        .acc_auth      (acc_auth),
        .done          (done),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request at a negedge, let it be sampled, land #1 after.
    task automatic do_req(input logic [2:0] op, input logic [3:0] a,
                          input logic [15:0] p, input logic [15:0] np,
                          input logic [15:0] amt);
        @(negedge clk);
        operation = op;
        acc_num   = a;
        pin       = p;
        new_pin   = np;
        amount    = amt;
        req       = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (balance !== 16'd0 || current_state !== 3'd0 ||
            done !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: bal=%0d st=%0d done=%b err=%b want 0/0/0/0",
                     balance, current_state, done, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || error !== 1'b0 || current_state !== 3'd0) begin
            n_bad++;
            $display("FAIL idle_after_reset: done=%b err=%b st=%0d want 0/0/0",
                     done, error, current_state);
        end
    endtask

    task automatic test_balance();
        @(negedge clk);
        acc_num = 4'd3;
        pin     = 16'd1003;
        #1;
        n_cmp++;
        if (acc_found !== 1'b1 || acc_auth !== 1'b1) begin
            n_bad++;
            $display("FAIL auth_ok: found=%b auth=%b want 1/1",
                     acc_found, acc_auth);
        end
        do_req(3'd1, 4'd3, 16'd1003, 16'd0, 16'd0);
        n_cmp++;
        if (balance !== 16'd500 || current_state !== 3'd1 ||
            done !== 1'b1 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL balance: bal=%0d st=%0d d=%b e=%b want 500/1/1/0",
                     balance, current_state, done, error);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (balance !== 16'd500 || current_state !== 3'd1 ||
            done !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL hold: bal=%0d st=%0d d=%b e=%b want 500/1/0/0",
                     balance, current_state, done, error);
        end
    endtask

    task automatic test_withdraw();
        do_req(3'd2, 4'd2, 16'd1002, 16'd0, 16'd200);
        n_cmp++;
        if (balance !== 16'd300 || current_state !== 3'd2 ||
            done !== 1'b1 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw_200: bal=%0d st=%0d d=%b e=%b want 300/2/1/0",
                     balance, current_state, done, error);
        end
        do_req(3'd2, 4'd2, 16'd1002, 16'd0, 16'd400);
        n_cmp++;
        if (balance !== 16'd300 || done !== 1'b0 || error !== 1'b1) begin
            n_bad++;
            $display("FAIL withdraw_over: bal=%0d d=%b e=%b want 300/0/1",
                     balance, done, error);
        end
        do_req(3'd2, 4'd2, 16'd1002, 16'd0, 16'd300);
        n_cmp++;
        if (balance !== 16'd0 || done !== 1'b1 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw_exact: bal=%0d d=%b e=%b want 0/1/0",
                     balance, done, error);
        end
    endtask

    task automatic test_deposit();
        do_req(3'd3, 4'd5, 16'd1005, 16'd0, 16'd65035);
        n_cmp++;
        if (balance !== 16'd65535 || current_state !== 3'd3 ||
            done !== 1'b1 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL deposit_max: bal=%0d st=%0d d=%b e=%b want 65535/3/1/0",
                     balance, current_state, done, error);
        end
        do_req(3'd3, 4'd5, 16'd1005, 16'd0, 16'd1);
        n_cmp++;
        if (balance !== 16'd65535 || done !== 1'b0 || error !== 1'b1) begin
            n_bad++;
            $display("FAIL deposit_ovf: bal=%0d d=%b e=%b want 65535/0/1",
                     balance, done, error);
        end
        do_req(3'd3, 4'd5, 16'd1005, 16'd0, 16'd0);
        n_cmp++;
        if (balance !== 16'd65535 || done !== 1'b1 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL deposit_zero: bal=%0d d=%b e=%b want 65535/1/0",
                     balance, done, error);
        end
    endtask

    task automatic test_auth_fail();
        @(negedge clk);
        acc_num = 4'd1;
        pin     = 16'd9999;
        #1;
        n_cmp++;
        if (acc_found !== 1'b1 || acc_auth !== 1'b0) begin
            n_bad++;
            $display("FAIL wrong_pin_comb: found=%b auth=%b want 1/0",
                     acc_found, acc_auth);
        end
        do_req(3'd1, 4'd1, 16'd9999, 16'd0, 16'd0);
        n_cmp++;
        if (error !== 1'b1 || done !== 1'b0 ||
            current_state !== 3'd0 || balance !== 16'd0) begin
            n_bad++;
            $display("FAIL wrong_pin: e=%b d=%b st=%0d bal=%0d want 1/0/0/0",
                     error, done, current_state, balance);
        end
        do_req(3'd1, 4'd12, 16'd1000, 16'd0, 16'd0);
        n_cmp++;
        if (acc_found !== 1'b0 || acc_auth !== 1'b0 || error !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_acc: found=%b auth=%b e=%b want 0/0/1",
                     acc_found, acc_auth, error);
        end
    endtask

    task automatic test_change_pin();
        do_req(3'd4, 4'd0, 16'd1000, 16'd4321, 16'd0);
        n_cmp++;
        if (done !== 1'b1 || current_state !== 3'd4 || balance !== 16'd500) begin
            n_bad++;
            $display("FAIL change_pin: d=%b st=%0d bal=%0d want 1/4/500",
                     done, current_state, balance);
        end
        do_req(3'd1, 4'd0, 16'd1000, 16'd0, 16'd0);
        n_cmp++;
        if (error !== 1'b1 || balance !== 16'd0) begin
            n_bad++;
            $display("FAIL old_pin: e=%b bal=%0d want 1/0", error, balance);
        end
        do_req(3'd1, 4'd0, 16'd4321, 16'd0, 16'd0);
        n_cmp++;
        if (done !== 1'b1 || balance !== 16'd500 || current_state !== 3'd1) begin
            n_bad++;
            $display("FAIL new_pin: d=%b bal=%0d st=%0d want 1/500/1",
                     done, balance, current_state);
        end
    endtask

    task automatic test_exit_invalid();
        do_req(3'd5, 4'd4, 16'd1004, 16'd0, 16'd0);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0 ||
            current_state !== 3'd0 || balance !== 16'd0) begin
            n_bad++;
            $display("FAIL exit: d=%b e=%b st=%0d bal=%0d want 1/0/0/0",
                     done, error, current_state, balance);
        end
        do_req(3'd7, 4'd4, 16'd1004, 16'd0, 16'd10);
        n_cmp++;
        if (error !== 1'b1 || done !== 1'b0 ||
            current_state !== 3'd6 || balance !== 16'd500) begin
            n_bad++;
            $display("FAIL invalid_op: e=%b d=%b st=%0d bal=%0d want 1/0/6/500",
                     error, done, current_state, balance);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        operation = 3'd3;
        acc_num   = 4'd7;
        pin       = 16'd1007;
        amount    = 16'd100;
        req       = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (balance !== 16'd600 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_dep: bal=%0d d=%b want 600/1", balance, done);
        end
        operation = 3'd2;
        amount    = 16'd50;
        @(posedge clk);
        #1;
        req = 1'b0;
        n_cmp++;
        if (balance !== 16'd550 || done !== 1'b1 || current_state !== 3'd2) begin
            n_bad++;
            $display("FAIL b2b_wd: bal=%0d d=%b st=%0d want 550/1/2",
                     balance, done, current_state);
        end
        // Reset lands while a deposit request is pending.
        @(negedge clk);
        operation = 3'd3;
        amount    = 16'd100;
        req       = 1'b1;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        n_cmp++;
        if (balance !== 16'd0 || current_state !== 3'd0 ||
            done !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: bal=%0d st=%0d d=%b e=%b want 0/0/0/0",
                     balance, current_state, done, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(3'd1, 4'd7, 16'd1007, 16'd0, 16'd0);
        n_cmp++;
        if (balance !== 16'd500 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_bal: bal=%0d d=%b want 500/1",
                     balance, done);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        operation = 3'd0;
        acc_num   = 4'd0;
        pin       = 16'd0;
        new_pin   = 16'd0;
        amount    = 16'd0;
        language  = 1'b0;
        test_reset();
        test_balance();
        test_withdraw();
        language = 1'b1;
        test_deposit();
        test_auth_fail();
        test_change_pin();
        test_exit_invalid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
